// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction-memory word address, tracks the
// in-flight read, and fills IF/ID with stall replay, redirect and halt handling.
module fetch_unit #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_WORD  = 32'h00000020,
  parameter logic [31:0]     HALT_WORD = 32'h00000030
) (
  input  logic            clk,
  input  logic            rst1,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] im_addr,
  input  logic [31:0]     im_dout,
  output logic            ifid_valid,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic            halted,
  output logic [15:0]     fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] f2_pc_q, f2_pc_d;
  logic            f2_valid_q, f2_valid_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [15:0]     fetch_count_q, fetch_count_d;

  // Address depends only on control inputs and state, never on im_dout.
  always_comb begin
    if (rst1)                          im_addr = RESET_PC;
    else if (redirect_valid)           im_addr = redirect_pc;
    else if (stall || state_q == HALT) im_addr = f2_pc_q;
    else                               im_addr = pc_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f2_pc_d       = f2_pc_q;
    f2_valid_d    = f2_valid_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      // The word in flight is discarded; the target arrives one edge later.
      pc_d         = redirect_pc + 1'b1;
      f2_pc_d      = redirect_pc;
      f2_valid_d   = 1'b1;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_WORD;
      state_d      = RUN;
    end else if (!stall && state_q == RUN) begin
      if (f2_valid_q && im_dout == HALT_WORD) begin
        // Freeze f2 on the marker so the memory keeps re-reading it.
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_WORD;
        state_d      = HALT;
      end else begin
        if (f2_valid_q) begin
          ifid_valid_d  = 1'b1;
          ifid_instr_d  = im_dout;
          ifid_pc_d     = f2_pc_q;
          fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                      : fetch_count_q + 16'd1;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_WORD;
        end
        f2_pc_d    = pc_q;
        f2_valid_d = 1'b1;
        pc_d       = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst1) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC + 1'b1;
      f2_pc_q       <= RESET_PC;
      f2_valid_q    <= 1'b1;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= NOP_WORD;
      ifid_pc_q     <= '0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f2_pc_q       <= f2_pc_d;
      f2_valid_q    <= f2_valid_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (reset PC 0 and 254) share stimulus and one
// instruction memory; each is compared against a delivery-order reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h00000020;
  localparam logic [31:0] HALT = 32'h00000030;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  im_addr_w [2];
  logic [31:0] im_dout_r [2];
  logic        ifid_valid_w [2];
  logic [31:0] ifid_instr_w [2];
  logic [7:0]  ifid_pc_w [2];
  logic        halted_w [2];
  logic [15:0] fetch_count_w [2];

  logic [31:0] mem [256];

  // Reference model: the next word address to hand to IF/ID plus the visible IF/ID state.
  logic [7:0]  m_rpc [2];
  logic [7:0]  m_nxt [2];
  logic        m_valid [2];
  logic [31:0] m_instr [2];
  logic [7:0]  m_pc [2];
  logic [15:0] m_cnt [2];
  logic        m_halt [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .RESET_PC(8'd0)) dut0 (
    .clk(clk), .rst1(rst1), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .im_addr(im_addr_w[0]), .im_dout(im_dout_r[0]),
    .ifid_valid(ifid_valid_w[0]), .ifid_instr(ifid_instr_w[0]), .ifid_pc(ifid_pc_w[0]),
    .halted(halted_w[0]), .fetch_count(fetch_count_w[0]));

  fetch_unit #(.PC_W(8), .RESET_PC(8'd254)) dut1 (
    .clk(clk), .rst1(rst1), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .im_addr(im_addr_w[1]), .im_dout(im_dout_r[1]),
    .ifid_valid(ifid_valid_w[1]), .ifid_instr(ifid_instr_w[1]), .ifid_pc(ifid_pc_w[1]),
    .halted(halted_w[1]), .fetch_count(fetch_count_w[1]));

  // Instruction memory with a registered read, one port per instance.
  always @(posedge clk) begin
    im_dout_r[0] <= mem[im_addr_w[0]];
    im_dout_r[1] <= mem[im_addr_w[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [7:0] rp);
    logic [7:0] ea;
    rst1 = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r)                    ea = m_rpc[i];
      else if (rv)              ea = rp;
      else if (s || m_halt[i])  ea = m_nxt[i];
      else                      ea = m_nxt[i] + 8'd1;
      chk($sformatf("im_addr%0d", i), {24'd0, im_addr_w[i]}, {24'd0, ea});
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_valid[i] = 1'b0; m_instr[i] = NOP; m_pc[i] = 8'd0; m_cnt[i] = 16'd0;
        m_halt[i] = 1'b0; m_nxt[i] = m_rpc[i];
      end else if (rv) begin
        m_valid[i] = 1'b0; m_instr[i] = NOP; m_halt[i] = 1'b0; m_nxt[i] = rp;
      end else if (!s && !m_halt[i]) begin
        if (mem[m_nxt[i]] == HALT) begin
          m_valid[i] = 1'b0; m_instr[i] = NOP; m_halt[i] = 1'b1;
        end else begin
          m_valid[i] = 1'b1; m_instr[i] = mem[m_nxt[i]]; m_pc[i] = m_nxt[i];
          if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
          m_nxt[i] = m_nxt[i] + 8'd1;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ifid_valid%0d", i), {31'd0, ifid_valid_w[i]}, {31'd0, m_valid[i]});
      chk($sformatf("ifid_instr%0d", i), ifid_instr_w[i], m_instr[i]);
      chk($sformatf("ifid_pc%0d", i), {24'd0, ifid_pc_w[i]}, {24'd0, m_pc[i]});
      chk($sformatf("halted%0d", i), {31'd0, halted_w[i]}, {31'd0, m_halt[i]});
      chk($sformatf("fetch_count%0d", i), {16'd0, fetch_count_w[i]}, {16'd0, m_cnt[i]});
    end
  endtask

  initial begin
    logic [31:0] w;
    logic        r, s, rv;
    logic [7:0]  rp;
    m_rpc[0] = 8'd0;
    m_rpc[1] = 8'd254;
    for (int i = 0; i < 2; i++) begin
      m_nxt[i] = m_rpc[i]; m_valid[i] = 1'b0; m_instr[i] = NOP;
      m_pc[i] = 8'd0; m_cnt[i] = 16'd0; m_halt[i] = 1'b0;
    end
    for (int a = 0; a < 256; a++) begin
      do w = $urandom; while (w == HALT);
      mem[a] = w;
    end
    mem[0]   = 32'h1111_0000;
    mem[254] = 32'h2222_00FE;
    mem[255] = 32'h3333_00FF;
    mem[69]  = HALT;

    @(posedge clk); #1;

    // Reset, then free-run four words.
    step(1, 0, 0, 0);
    chk("rst_valid", {31'd0, ifid_valid_w[0]}, 32'd0);
    chk("rst_instr", ifid_instr_w[0], NOP);
    chk("rst_count", {16'd0, fetch_count_w[0]}, 32'd0);
    step(0, 0, 0, 0);
    chk("first_word", ifid_instr_w[0], mem[0]);
    chk("wrap_254", {24'd0, ifid_pc_w[1]}, 32'd254);
    step(0, 0, 0, 0);
    chk("wrap_255", {24'd0, ifid_pc_w[1]}, 32'd255);
    step(0, 0, 0, 0);
    chk("wrap_0_pc", {24'd0, ifid_pc_w[1]}, 32'd0);
    chk("wrap_0_instr", ifid_instr_w[1], mem[0]);
    step(0, 0, 0, 0);
    chk("count4", {16'd0, fetch_count_w[0]}, 32'd4);
    chk("pc3", {24'd0, ifid_pc_w[0]}, 32'd3);

    // Stall for three cycles while B sits in IF/ID.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      chk("stall_addr", {24'd0, im_addr_w[0]}, 32'd2);
    end
    step(0, 0, 0, 0);
    chk("after_stall", ifid_instr_w[0], mem[2]);

    // Redirect alone, then redirect together with stall.
    step(0, 0, 1, 8'd32);
    step(0, 0, 0, 0);
    chk("redir_target", ifid_instr_w[0], mem[32]);
    step(0, 0, 0, 0);
    step(0, 1, 1, 8'd32);
    step(0, 0, 0, 0);
    chk("redir_stall_pc", {24'd0, ifid_pc_w[0]}, 32'd32);

    // Run into the halt marker at 69 and sit there.
    step(0, 0, 1, 8'd60);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    chk("halt_flag", {31'd0, halted_w[0]}, 32'd1);
    chk("halt_last_pc", {24'd0, ifid_pc_w[0]}, 32'd68);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0);
      chk("halt_addr", {24'd0, im_addr_w[0]}, 32'd69);
    end
    step(0, 0, 1, 8'd0);
    step(0, 0, 0, 0);
    chk("resume", {31'd0, halted_w[0]}, 32'd0);

    // Reset pulsed in the middle of a stall.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_mid_stall", {24'd0, ifid_pc_w[1]}, 32'd254);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rp = 8'd66;
        1:       rp = 8'd252;
        default: rp = 8'($urandom);
      endcase
      step(r, s, rv, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
